// File: rtl/fetch_decode.sv
// fetch_decode: single-outstanding instruction fetch plus IF/ID register.
// Splits the held instruction into fields and a format-decoded immediate.
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  f3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  f7,
    output logic [31:0] immediate
);
    typedef enum logic {REQ, WAIT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, fpc_q, fpc_d, buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
    logic [31:0] id_pc_q, id_pc_d, id_instr_q, id_instr_d;
    logic        kill_q, kill_d, buf_valid_q, buf_valid_d, id_valid_q, id_valid_d;
    logic        grant, deliver, take;

    assign imem_req  = reset && state_q == REQ && !stall && !buf_valid_q;
    assign imem_addr = pc_q & ~32'd3;
    assign grant     = imem_req && imem_gnt;
    assign deliver   = state_q == WAIT && imem_rvalid;
    assign take      = deliver && !kill_q;

    always_comb begin
        state_d     = grant ? WAIT : deliver ? REQ : state_q;
        pc_d        = grant ? pc_q + PC_STEP : pc_q;
        fpc_d       = grant ? pc_q : fpc_q;
        kill_d      = deliver ? 1'b0 : kill_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        if (take && stall && id_valid_q) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = fpc_q;
        end else if (take) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = fpc_q;
        end else if (!stall && buf_valid_q) begin
            buf_valid_d = 1'b0;
            id_valid_d  = 1'b1;
            id_instr_d  = buf_instr_q;
            id_pc_d     = buf_pc_q;
        end else if (!stall) begin
            id_valid_d = 1'b0;
        end
        // a redirect racing a response drops it here, so kill is only armed while a reply is still owed
        if (redirect) begin
            id_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            pc_d        = redirect_pc & ~32'd3;
            kill_d      = (state_q == WAIT && !imem_rvalid) || grant;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            fpc_q       <= '0;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fpc_q       <= fpc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_valid_q ? id_instr_q : '0;
    assign opcode   = id_instr[6:0];
    assign rd       = id_instr[11:7];
    assign f3       = id_instr[14:12];
    assign rs1      = id_instr[19:15];
    assign rs2      = id_instr[24:20];
    assign f7       = id_instr[31:25];

    always_comb begin
        immediate = (opcode == 7'b0010011 || opcode == 7'b0000011 || opcode == 7'b1100111) ?
                        {{20{id_instr[31]}}, id_instr[31:20]} :
                    opcode == 7'b0100011 ? {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]} :
                    opcode == 7'b1100011 ? {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                                            id_instr[30:25], id_instr[11:8], 1'b0} :
                    (opcode == 7'b0110111 || opcode == 7'b0010111) ? {id_instr[31:12], 12'b0} :
                    opcode == 7'b1101111 ? {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                                            id_instr[20], id_instr[30:21], 1'b0} : '0;
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed scenarios plus a randomized run checked against a
// transaction-level model of the instruction stream the ID stage must present.
module tb_fetch_decode;
    logic        clock = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        id_valid;
    logic [31:0] id_pc, id_instr, immediate;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    int total = 0, bad = 0;
    int lat = 1, cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] mem [logic [31:0]];
    logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};

    fetch_decode dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .opcode(opcode), .rd(rd), .f3(f3), .rs1(rs1), .rs2(rs2), .f7(f7), .immediate(immediate)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
        return {h[31:7], ops[(h >> 3) % 10]};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [31:0] s;
        s = w[31] ? 32'hFFFF_FFFF : 32'h0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return (s << 12) | (w >> 20);
            7'h23: return (s << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
            7'h63: return (s << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
                          | (((w >> 8) & 32'hF) << 1);
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F: return (s << 20) | (w & 32'h000F_F000) | (((w >> 20) & 32'h1) << 11)
                          | (((w >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    // one-outstanding memory: grant recorded at the edge, response presented lat cycles later
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset && imem_req && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
        end
    end

    always @(negedge clock) begin
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= $urandom;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; lat = 1;
        q_addr.delete(); q_due.delete();
        tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", imem_req); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%0h want=0", id_pc); end
        total++; if (id_instr !== 32'h0 || opcode !== 7'h0) begin bad++; $display("FAIL rst_instr got=%0h/%0h want=0", id_instr, opcode); end
        total++; if (immediate !== 32'h0) begin bad++; $display("FAIL rst_imm got=%0h want=0", immediate); end
    endtask

    task automatic test_basic();
        reset = 1'b1; imem_gnt = 1'b1; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%0h@%0h want=1@0", imem_req, imem_addr); end
        tick();
        total++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL wait_phase got req=%0h v=%0h want 0 0", imem_req, id_valid); end
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin bad++; $display("FAIL addi_pc got v=%0h pc=%0h want 1 0", id_valid, id_pc); end
        total++; if (opcode !== 7'h13 || rd !== 5'd1 || rs1 !== 5'd0) begin bad++; $display("FAIL addi_fields got op=%0h rd=%0d rs1=%0d want 13 1 0", opcode, rd, rs1); end
        total++; if (immediate !== 32'd5) begin bad++; $display("FAIL addi_imm got=%0h want=5", immediate); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL second_addr got=%0h@%0h want=1@4", imem_req, imem_addr); end
        tick();
        total++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin bad++; $display("FAIL bubble got v=%0h i=%0h want 0 0", id_valid, id_instr); end
        tick();
        total++; if (opcode !== 7'h63 || immediate !== 32'hFFFF_FFFC || id_pc !== 32'h4) begin bad++; $display("FAIL beq got op=%0h imm=%0h pc=%0h want 63 fffffffc 4", opcode, immediate, id_pc); end
        tick(); tick();
        total++; if (opcode !== 7'h37 || immediate !== 32'h1234_5000 || id_pc !== 32'h8) begin bad++; $display("FAIL lui got op=%0h imm=%0h pc=%0h want 37 12345000 8", opcode, immediate, id_pc); end
    endtask

    task automatic test_stall();
        lat = 3;
        tick();
        stall = 1'b1; #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0h want=0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%0h want=0", i, imem_req); end
            if (i >= 2) begin
                total++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== mem_word(32'hC)) begin bad++; $display("FAIL stall_hold%0d got v=%0h pc=%0h i=%0h want 1 c %0h", i, id_valid, id_pc, id_instr, mem_word(32'hC)); end
            end
        end
        stall = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL stall_resume got=%0h@%0h want=1@10", imem_req, imem_addr); end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stall_bubble got=%0h want=0", id_valid); end
    endtask

    task automatic test_redirect();
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1; lat = 2;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0; #1;
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL redir_wait got v=%0h req=%0h want 0 0", id_valid, imem_req); end
        tick();
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_drop got v=%0h req=%0h a=%0h want 0 1 100", id_valid, imem_req, imem_addr); end
        lat = 1;
        tick(); tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin bad++; $display("FAIL redir_land got v=%0h pc=%0h i=%0h want 1 100 %0h", id_valid, id_pc, id_instr, mem_word(32'h100)); end
        tick();
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0; #1;
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL redir_rvalid got v=%0h req=%0h a=%0h want 0 1 200", id_valid, imem_req, imem_addr); end
        tick(); tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin bad++; $display("FAIL redir_rvalid_land got v=%0h pc=%0h want 1 200", id_valid, id_pc); end
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        tick();
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin bad++; $display("FAIL redir_gnt got v=%0h req=%0h a=%0h want 0 1 300", id_valid, imem_req, imem_addr); end
        tick(); tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h300) begin bad++; $display("FAIL redir_gnt_land got v=%0h pc=%0h want 1 300", id_valid, id_pc); end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect = 1'b0;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL redir_stall_flush got=%0h want=0", id_valid); end
        tick();
        total++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL redir_stall_hold got req=%0h v=%0h want 0 0", imem_req, id_valid); end
        stall = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin bad++; $display("FAIL redir_stall_restart got=%0h@%0h want=1@400", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem_gnt = 1'b1; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%0h@%0h want=1@fffffffc", imem_req, imem_addr); end
        tick(); tick();
        total++; if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL wrap_next got pc=%0h a=%0h req=%0h want fffffffc 0 1", id_pc, imem_addr, imem_req); end
    endtask

    task automatic test_reset_mid_wait();
        lat = 3;
        tick();
        reset = 1'b0; #1;
        total++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || immediate !== 32'h0) begin bad++; $display("FAIL midrst_out got req=%0h v=%0h i=%0h imm=%0h want 0", imem_req, id_valid, id_instr, immediate); end
        tick();
        reset = 1'b1; imem_gnt = 1'b0;
        tick(); tick();
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_late got v=%0h req=%0h a=%0h want 0 1 0", id_valid, imem_req, imem_addr); end
        lat = 1; imem_gnt = 1'b1;
        tick(); tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0050_0093) begin bad++; $display("FAIL midrst_refetch got v=%0h pc=%0h i=%0h want 1 0 500093", id_valid, id_pc, id_instr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_next, held_pc, held_instr, w;
        logic        pv, ps, pr;
        int          deliveries;
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1;
        exp_next = 32'h0; held_pc = '0; held_instr = '0; pv = 0; ps = 0; pr = 0; deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            if (stall) begin
                total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rnd_stall_req c=%0d got=%0h want=0", c, imem_req); end
            end
            if (pr) begin
                total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush c=%0d got=%0h want=0", c, id_valid); end
            end else if (id_valid && (!pv || !ps)) begin
                w = mem_word(exp_next);
                total++; if (id_pc !== exp_next || id_instr !== w) begin bad++; $display("FAIL rnd_stream c=%0d got pc=%0h i=%0h want %0h %0h", c, id_pc, id_instr, exp_next, w); end
                total++; if (immediate !== ref_imm(w)) begin bad++; $display("FAIL rnd_imm c=%0d got=%0h want=%0h", c, immediate, ref_imm(w)); end
                total++; if ({f7, rs2, rs1, f3, rd, opcode} !== w) begin bad++; $display("FAIL rnd_fields c=%0d got=%0h want=%0h", c, {f7, rs2, rs1, f3, rd, opcode}, w); end
                held_pc = exp_next; held_instr = w; exp_next = exp_next + 32'd4; deliveries++;
            end else if (pv && ps) begin
                total++; if (id_valid !== 1'b1 || id_pc !== held_pc || id_instr !== held_instr) begin bad++; $display("FAIL rnd_hold c=%0d got v=%0h pc=%0h want 1 %0h", c, id_valid, id_pc, held_pc); end
            end else if (!id_valid) begin
                total++; if (id_instr !== 32'h0 || immediate !== 32'h0) begin bad++; $display("FAIL rnd_nop c=%0d got i=%0h imm=%0h want 0 0", c, id_instr, immediate); end
            end
            pv = id_valid; ps = 1'b0; pr = 1'b0;
            stall = ($urandom % 4) == 0;
            redirect = ($urandom % 20) == 0;
            imem_gnt = ($urandom % 10) < 7;
            lat = $urandom_range(1, 3);
            if (redirect) begin
                redirect_pc = ($urandom % 8 == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 1023);
                exp_next = redirect_pc & ~32'd3;
            end
            ps = stall; pr = redirect;
            @(negedge clock);
        end
        redirect = 1'b0; stall = 1'b0;
        total++; if (deliveries < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", deliveries); end
    endtask

    initial begin
        mem[32'h0] = 32'h0050_0093;
        mem[32'h4] = 32'hFE00_0EE3;
        mem[32'h8] = 32'h1234_50B7;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
